// File: rtl/axi_lite_cmd_pkg.sv
// Shared types and widths for the AXI-lite command master.
// State enum plus address / data / counter widths.
package axi_lite_cmd_pkg;

  localparam int ADDR_W  = 4;
  localparam int WDATA_W = 4;
  localparam int RDATA_W = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

endpackage

// File: rtl/axi_timeout_ctr.sv
// Handshake wait counter for the AXI-lite command master.
// expired fires on the edge where the count would reach TIMEOUT.
module axi_timeout_ctr
  import axi_lite_cmd_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A clear in the same cycle means a handshake, which wins.
  assign expired = enable && !clear &&
                   (cnt == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-lite master driven by a simple command port.
// All outputs come straight from registers; timeouts abort to an error response.
module axi_lite_cmd_master
  import axi_lite_cmd_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [WDATA_W-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [RDATA_W-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               m_arvalid,
  output logic [ADDR_W-1:0]  m_araddr,
  input  logic               s_arready,
  input  logic               s_rvalid,
  input  logic [RDATA_W-1:0] s_rdata,
  output logic               m_rready,
  output logic               m_awvalid,
  output logic [ADDR_W-1:0]  m_awaddr,
  input  logic               s_awready,
  output logic               m_wvalid,
  output logic [WDATA_W-1:0] m_wdata,
  input  logic               s_wready
);

  state_t state, state_n;

  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [WDATA_W-1:0] wdata_q, wdata_n;
  logic [RDATA_W-1:0] rdata_n;
  logic cmd_ready_n, rsp_valid_n, rsp_err_n;
  logic awvalid_n, wvalid_n;
  logic arvalid_n, rready_n;
  logic aw_hs, w_hs, ar_hs, r_hs;
  logic busy, tmo_clr, tmo;

  assign aw_hs = m_awvalid && s_awready;
  assign w_hs  = m_wvalid && s_wready;
  assign ar_hs = m_arvalid && s_arready;
  assign r_hs  = m_rready && s_rvalid;

  assign busy = (state == WR) ||
                (state == RD_ADDR) ||
                (state == RD_DATA);

  assign tmo_clr = !busy || aw_hs || w_hs ||
                   ar_hs || r_hs;

  axi_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clr),
    .enable  (busy),
    .expired (tmo)
  );

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;

  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    rdata_n     = rsp_rdata;
    rsp_valid_n = rsp_valid;
    rsp_err_n   = rsp_err;
    awvalid_n   = m_awvalid;
    wvalid_n    = m_wvalid;
    arvalid_n   = m_arvalid;
    rready_n    = m_rready;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_n  = cmd_addr;
          wdata_n = cmd_wdata;
          if (cmd_write) begin
            state_n   = WR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_ADDR;
            arvalid_n = 1'b1;
          end
        end
      end
      WR: begin
        awvalid_n = m_awvalid && !aw_hs;
        wvalid_n  = m_wvalid && !w_hs;
        if (!awvalid_n && !wvalid_n) begin
          state_n     = RSP;
          rsp_valid_n = 1'b1;
          rdata_n     = '0;
          rsp_err_n   = 1'b0;
        end else if (tmo) begin
          state_n     = RSP;
          awvalid_n   = 1'b0;
          wvalid_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rdata_n     = '0;
          rsp_err_n   = 1'b1;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          state_n   = RD_DATA;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end else if (tmo) begin
          state_n     = RSP;
          arvalid_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rdata_n     = '0;
          rsp_err_n   = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          state_n     = RSP;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rdata_n     = s_rdata;
          rsp_err_n   = 1'b0;
        end else if (tmo) begin
          state_n     = RSP;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rdata_n     = '0;
          rsp_err_n   = 1'b1;
        end
      end
      RSP: begin
        if (rsp_valid && rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    cmd_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rdata_n;
      rsp_err   <= rsp_err_n;
      m_awvalid <= awvalid_n;
      m_wvalid  <= wvalid_n;
      m_arvalid <= arvalid_n;
      m_rready  <= rready_n;
    end
  end

endmodule
